// File: rtl/alu_cmd_pkg.sv
// Shared opcode, flag-index and FSM-state definitions for the ALU command engine.
package alu_cmd_pkg;

    localparam logic [3:0] OP_ADD     = 4'd0;
    localparam logic [3:0] OP_SUB     = 4'd1;
    localparam logic [3:0] OP_AND     = 4'd2;
    localparam logic [3:0] OP_OR      = 4'd3;
    localparam logic [3:0] OP_XOR     = 4'd4;
    localparam logic [3:0] OP_NOT     = 4'd5;
    localparam logic [3:0] OP_SHL     = 4'd6;
    localparam logic [3:0] OP_SHR     = 4'd7;
    localparam logic [3:0] OP_SAR     = 4'd8;
    localparam logic [3:0] OP_ROL     = 4'd9;
    localparam logic [3:0] OP_ROR     = 4'd10;
    localparam logic [3:0] OP_INC     = 4'd11;
    localparam logic [3:0] OP_DEC     = 4'd12;
    localparam logic [3:0] OP_PASSX   = 4'd13;
    localparam logic [3:0] OP_PASSY   = 4'd14;
    localparam logic [3:0] OP_ILLEGAL = 4'd15;

    localparam int FLG_ZERO  = 0;
    localparam int FLG_CARRY = 1;
    localparam int FLG_OVF   = 2;
    localparam int FLG_NEG   = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        CAPT = 2'd2
    } state_t;

endpackage

// File: rtl/alu_cmd_if.sv
// Command and response handshake bundle between a controller (master) and the engine (slave).
interface alu_cmd_if #(parameter int WIDTH = 8);

    logic             cmd_valid;
    logic             cmd_ready;
    logic [WIDTH-1:0] cmd_x;
    logic [WIDTH-1:0] cmd_y;
    logic [3:0]       cmd_sel;
    logic             cmd_chain;

    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_out;
    logic [3:0]       rsp_flags;
    logic             rsp_illegal;

    modport master (
        output cmd_valid, cmd_x, cmd_y, cmd_sel, cmd_chain, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_out, rsp_flags, rsp_illegal
    );

    modport slave (
        input  cmd_valid, cmd_x, cmd_y, cmd_sel, cmd_chain, rsp_ready,
        output cmd_ready, rsp_valid, rsp_out, rsp_flags, rsp_illegal
    );

endinterface

// File: rtl/alu.sv
// Combinational ALU: 15 operations on x/y with zero, carry, overflow and negative flags.
module alu
    import alu_cmd_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic [3:0]       sel,
    output logic [WIDTH-1:0] out,
    output logic             zero,
    output logic             carry,
    output logic             overflow,
    output logic             negative
);

    localparam logic [WIDTH:0] ONE = (WIDTH+1)'(1);

    always_comb begin
        // NOTE: every output gets a default before the case so no path leaves it unassigned (no latch).
        out      = '0;
        carry    = 1'b0;
        overflow = 1'b0;
        case (sel)
            OP_ADD: begin
                {carry, out} = {1'b0, x} + {1'b0, y};
                overflow     = (x[WIDTH-1] == y[WIDTH-1]) && (out[WIDTH-1] != x[WIDTH-1]);
            end
            OP_SUB: begin
                // carry is the borrow out: set when x < y unsigned
                {carry, out} = {1'b0, x} - {1'b0, y};
                overflow     = (x[WIDTH-1] != y[WIDTH-1]) && (out[WIDTH-1] != x[WIDTH-1]);
            end
            OP_AND:   out = x & y;
            OP_OR:    out = x | y;
            OP_XOR:   out = x ^ y;
            OP_NOT:   out = ~x;
            OP_SHL:   begin out = {x[WIDTH-2:0], 1'b0};        carry = x[WIDTH-1]; end
            OP_SHR:   begin out = {1'b0, x[WIDTH-1:1]};        carry = x[0];       end
            OP_SAR:   begin out = {x[WIDTH-1], x[WIDTH-1:1]};  carry = x[0];       end
            OP_ROL:   begin out = {x[WIDTH-2:0], x[WIDTH-1]};  carry = x[WIDTH-1]; end
            OP_ROR:   begin out = {x[0], x[WIDTH-1:1]};        carry = x[0];       end
            OP_INC: begin
                {carry, out} = {1'b0, x} + ONE;
                overflow     = !x[WIDTH-1] && out[WIDTH-1];
            end
            OP_DEC: begin
                {carry, out} = {1'b0, x} - ONE;
                overflow     = x[WIDTH-1] && !out[WIDTH-1];
            end
            OP_PASSX: out = x;
            OP_PASSY: out = y;
            default:  out = '0;
        endcase
    end

    assign zero     = (out == '0);
    assign negative = out[WIDTH-1];

endmodule

// File: rtl/alu_rsp_fifo.sv
// Synchronous FIFO with occupancy count; pointers wrap naturally over a power-of-two depth.
module alu_rsp_fifo #(
    parameter int WIDTH = 13,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || pop);
    assign dout    = mem[rd_ptr];

    // NOTE: storage has no reset; the pointers and count alone define what is valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/alu_cmd_engine.sv
// Command front-end for alu: IDLE/EXEC/CAPT sequencer plus response FIFO.
// Optional ALU_CMD_STATS_EN adds saturating push/overflow counters stat_ops and stat_ovf.
module alu_cmd_engine
    import alu_cmd_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    alu_cmd_if.slave    bus
`ifdef ALU_CMD_STATS_EN
    ,
    output logic [15:0] stat_ops,
    output logic [15:0] stat_ovf
`endif
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int EW = WIDTH + 5;

    state_t           state;
    state_t           state_nxt;
    logic             accept;
    logic             load_ops;
    logic             push;

    logic [WIDTH-1:0] op_x;
    logic [WIDTH-1:0] op_y;
    logic [3:0]       op_sel;
    logic [WIDTH-1:0] last_result;

    logic [WIDTH-1:0] alu_out;
    logic             alu_zero;
    logic             alu_carry;
    logic             alu_ovf;
    logic             alu_neg;

    logic             illegal;
    logic [WIDTH-1:0] res_out;
    logic [3:0]       res_flags;

    logic [EW-1:0]    fifo_dout;
    logic             fifo_full;
    logic             fifo_empty;
    logic             fifo_pop;
    logic [CW-1:0]    fifo_count;

    alu #(.WIDTH(WIDTH)) u_alu (
        .x        (op_x),
        .y        (op_y),
        .sel      (op_sel),
        .out      (alu_out),
        .zero     (alu_zero),
        .carry    (alu_carry),
        .overflow (alu_ovf),
        .negative (alu_neg)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = EXEC;
            EXEC:    state_nxt = CAPT;
            CAPT:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Ready only while idle with a free slot, so the eventual push can never overflow.
    always_comb begin
        bus.cmd_ready = rst_n && (state == IDLE) && (fifo_count < CW'(DEPTH));
        accept        = bus.cmd_valid && bus.cmd_ready;
        load_ops      = (state == IDLE) && accept;
        push          = (state == CAPT);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            op_x        <= '0;
            op_y        <= '0;
            op_sel      <= '0;
            last_result <= '0;
        end else begin
            if (load_ops) begin
                op_x   <= bus.cmd_chain ? last_result : bus.cmd_x;
                op_y   <= bus.cmd_y;
                op_sel <= bus.cmd_sel;
            end
            if (push) last_result <= res_out;
        end
    end

    assign illegal   = (op_sel == OP_ILLEGAL);
    assign res_out   = illegal ? '0 : alu_out;
    assign res_flags = illegal ? 4'b0000 : {alu_neg, alu_ovf, alu_carry, alu_zero};

    alu_rsp_fifo #(.WIDTH(EW), .DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (fifo_pop),
        .din   ({illegal, res_flags, res_out}),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign fifo_pop      = bus.rsp_ready && !fifo_empty;
    assign bus.rsp_valid = !fifo_empty;
    assign {bus.rsp_illegal, bus.rsp_flags, bus.rsp_out} = fifo_empty ? '0 : fifo_dout;

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(push && fifo_full && !fifo_pop));

`ifdef ALU_CMD_STATS_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stat_ops <= '0;
            stat_ovf <= '0;
        end else if (push) begin
            if (stat_ops != 16'hFFFF) stat_ops <= stat_ops + 16'd1;
            if (res_flags[FLG_OVF] && stat_ovf != 16'hFFFF) stat_ovf <= stat_ovf + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_alu_cmd_engine.sv
// Scoreboard bench for alu_cmd_engine: directed cases then randomized traffic vs. an arithmetic model.
module tb_alu_cmd_engine;

    localparam int W = 8;
    localparam int D = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    alu_cmd_if #(.WIDTH(W)) bus();

`ifdef ALU_CMD_STATS_EN
    logic [15:0] stat_ops;
    logic [15:0] stat_ovf;
`endif

    alu_cmd_engine #(.WIDTH(W), .DEPTH(D)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
`ifdef ALU_CMD_STATS_EN
        ,
        .stat_ops (stat_ops),
        .stat_ovf (stat_ovf)
`endif
    );

    typedef struct {
        logic [7:0] out;
        logic [3:0] flags;
        logic       illegal;
        int         acc_cyc;
        bit         chk_lat;
    } exp_t;

    exp_t sb[$];
    int   vectors = 0;
    int   errors  = 0;
    int   cyc     = 0;
    int   model_last = 0;
    int   model_ops  = 0;
    int   model_ovf  = 0;
    bit   rand_done;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: unsigned/signed integer arithmetic on the 8-bit operands.
    function automatic exp_t model(input int x, input int y, input int sel);
        exp_t e;
        int r, s, sx, sy;
        bit c, v;
        sx = (x > 127) ? x - 256 : x;
        sy = (y > 127) ? y - 256 : y;
        r = 0; c = 0; v = 0;
        e.illegal = 1'b0;
        case (sel)
            0:  begin r = x + y; c = (r > 255); s = sx + sy; v = (s > 127) || (s < -128); end
            1:  begin r = x - y; c = (x < y);   s = sx - sy; v = (s > 127) || (s < -128); end
            2:  r = x & y;
            3:  r = x | y;
            4:  r = x ^ y;
            5:  r = 255 - x;
            6:  begin r = x * 2; c = (x > 127); end
            7:  begin r = x / 2; c = (x % 2) != 0; end
            8:  begin r = x / 2 + ((x > 127) ? 128 : 0); c = (x % 2) != 0; end
            9:  begin r = (x * 2) % 256 + x / 128; c = (x > 127); end
            10: begin r = x / 2 + (x % 2) * 128; c = (x % 2) != 0; end
            11: begin r = x + 1; c = (r > 255); v = (x == 127); end
            12: begin r = x - 1; c = (x == 0);  v = (x == 128); end
            13: r = x;
            14: r = y;
            default: e.illegal = 1'b1;
        endcase
        r = r & 255;
        if (e.illegal) begin
            e.out   = 8'd0;
            e.flags = 4'd0;
        end else begin
            e.out   = 8'(r);
            e.flags = {r > 127, v, c, r == 0};
        end
        e.acc_cyc = 0;
        e.chk_lat = 1'b0;
        return e;
    endfunction

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send(input int x, input int y, input int sel, input bit chain, input bit chk_lat = 1'b0);
        exp_t e;
        int   budget;
        bus.cmd_valid = 1'b1;
        bus.cmd_x     = 8'(x);
        bus.cmd_y     = 8'(y);
        bus.cmd_sel   = 4'(sel);
        bus.cmd_chain = chain;
        budget = 0;
        while (!bus.cmd_ready && budget < 200) begin
            @(negedge clk);
            budget++;
        end
        if (!bus.cmd_ready) begin
            check("cmd_accept_timeout", {31'd0, bus.cmd_ready}, 32'd1);
            bus.cmd_valid = 1'b0;
            return;
        end
        e = model(chain ? model_last : x, y, sel);
        model_last = e.out;
        if (model_ops < 65535) model_ops++;
        if (e.flags[2] && model_ovf < 65535) model_ovf++;
        @(posedge clk);
        #1;
        e.acc_cyc = cyc;
        e.chk_lat = chk_lat;
        sb.push_back(e);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int budget = 0;
        while (sb.size() != 0 && budget < 400) begin
            @(negedge clk);
            budget++;
        end
        if (sb.size() != 0) check("drain_timeout", sb.size(), 32'd0);
        @(negedge clk);
    endtask

    // Monitor: pops the scoreboard on every handshake and checks head stability under backpressure.
    initial begin : monitor
        exp_t        e;
        bit          stall_prev = 1'b0;
        logic [12:0] held = '0;
        forever begin
            @(negedge clk);
            #1;
            if (!rst_n) begin
                stall_prev = 1'b0;
            end else begin
                if (stall_prev)
                    check("stable_head", {19'd0, bus.rsp_illegal, bus.rsp_flags, bus.rsp_out}, {19'd0, held});
                if (bus.rsp_valid && bus.rsp_ready) begin
                    if (sb.size() == 0) begin
                        vectors++;
                        errors++;
                        $display("FAIL unexpected_rsp: got out=0x%0h with nothing outstanding", bus.rsp_out);
                    end else begin
                        e = sb.pop_front();
                        check("rsp_out",     bus.rsp_out,     e.out);
                        check("rsp_flags",   bus.rsp_flags,   e.flags);
                        check("rsp_illegal", bus.rsp_illegal, e.illegal);
                        if (e.chk_lat) check("latency", cyc + 1 - e.acc_cyc, 32'd3);
                    end
                end
                stall_prev = bus.rsp_valid && !bus.rsp_ready;
                held       = {bus.rsp_illegal, bus.rsp_flags, bus.rsp_out};
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        rst_n         = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.cmd_x     = '0;
        bus.cmd_y     = '0;
        bus.cmd_sel   = '0;
        bus.cmd_chain = 1'b0;
        bus.rsp_ready = 1'b0;

        repeat (3) @(negedge clk);
        check("rst_cmd_ready", bus.cmd_ready,   32'd0);
        check("rst_rsp_valid", bus.rsp_valid,   32'd0);
        check("rst_rsp_data",  {bus.rsp_illegal, bus.rsp_flags, bus.rsp_out}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("ready_after_rst", bus.cmd_ready, 32'd1);
        @(negedge clk);

        // Directed arithmetic cases with an always-ready consumer
        bus.rsp_ready = 1'b1;
        send(25, 15, 0, 1'b0, 1'b1);
        wait_drain();
        send(128, 128, 0, 1'b0);
        send(255, 255, 0, 1'b0);
        send(0, 1, 0, 1'b1);
        wait_drain();

        // Backpressure: FIFO fills after four accepts
        bus.rsp_ready = 1'b0;
        for (int i = 0; i < 4; i++) send(10 * i + 1, i, 0, 1'b0);
        repeat (3) @(negedge clk);
        check("ready_when_full", bus.cmd_ready, 32'd0);
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        check("ready_after_pop", bus.cmd_ready, 32'd1);
        send(100, 5, 1, 1'b0);
        bus.rsp_ready = 1'b1;
        send(7, 3, 4, 1'b0);
        wait_drain();

        // Illegal opcode clears the chain source
        send(7, 9, 15, 1'b0);
        send(0, 3, 0, 1'b1);
        wait_drain();

        // Reset while a third command is in EXEC with two responses queued
        bus.rsp_ready = 1'b0;
        send(10, 20, 0, 1'b0);
        send(3, 4, 1, 1'b0);
        repeat (3) @(negedge clk);
        send(50, 60, 0, 1'b0);
        rst_n = 1'b0;
        @(negedge clk);
        check("rsp_valid_in_rst", bus.rsp_valid, 32'd0);
        check("cmd_ready_in_rst", bus.cmd_ready, 32'd0);
        sb.delete();
        model_last = 0;
        model_ops  = 0;
        model_ovf  = 0;
        rst_n = 1'b1;
        @(negedge clk);
        check("ready_after_rst2", bus.cmd_ready, 32'd1);
`ifdef ALU_CMD_STATS_EN
        check("stat_ops_rst", stat_ops, 32'd0);
        check("stat_ovf_rst", stat_ovf, 32'd0);
`endif
        repeat (4) @(negedge clk);
        check("no_ghost_rsp", bus.rsp_valid, 32'd0);
        bus.rsp_ready = 1'b1;
        send(200, 5, 0, 1'b1);
        wait_drain();

        // Randomized traffic with a randomly stalling consumer
        rand_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 80; i++)
                    send($urandom_range(0, 255), $urandom_range(0, 255),
                         $urandom_range(0, 15), ($urandom_range(0, 3) == 0));
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    @(negedge clk);
                    bus.rsp_ready = ($urandom_range(0, 2) != 0);
                end
            end
        join
        bus.rsp_ready = 1'b1;
        wait_drain();

`ifdef ALU_CMD_STATS_EN
        check("stat_ops", stat_ops, model_ops);
        check("stat_ovf", stat_ovf, model_ovf);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/alu_cmd_engine.md
Name: alu_cmd_engine

Overview:
- Sequential command front-end for the existing combinational `alu` (ports x, y, sel, out, zero, carry, overflow, negative).
- Accepts operation commands over a valid/ready handshake, registers operands into the ALU, and captures result plus flags.
- Returns responses through a small response FIFO with valid/ready. It is the responder side of the command stream that benches and controllers drive into the ALU.

Parameters:
- WIDTH, 8, operand/result width; must match `alu`.
- DEPTH, 4, response FIFO entries; power of two, at least 2.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  engine can accept a command this cycle.
- cmd_x  in  WIDTH  operand x.
- cmd_y  in  WIDTH  operand y.
- cmd_sel  in  4  ALU opcode (0..14).
- cmd_chain  in  1  1 = use last result as x and ignore cmd_x.
- rsp_valid  out  1  FIFO head valid.
- rsp_ready  in  1  consumer takes head.
- rsp_out  out  WIDTH  result.
- rsp_flags  out  4  {negative, overflow, carry, zero}.
- rsp_illegal  out  1  opcode was 15; result forced to 0.

Behaviour:
- Interface decision: one clock (clk); reset rst_n is synchronous and active-low.
- Reset values:
  - cmd_ready=0 during reset and 1 the cycle after.
  - rsp_valid=0; rsp_out, rsp_flags and rsp_illegal = 0.
  - FIFO empty; FSM in IDLE; last-result register = 0.
- FSM states: IDLE, EXEC, CAPT.
  - IDLE: accept when cmd_valid && cmd_ready. Latch x (or last result if cmd_chain), y and sel into operand regs, then go to EXEC.
  - EXEC: the ALU evaluates registered operands; go to CAPT.
  - CAPT: push {out, flags, illegal} into the FIFO and update the last-result register, even for an illegal opcode (value 0). Return to IDLE.
- Throughput: one command per 3 cycles.
- Latency: response is visible on rsp_valid 3 cycles after the accept edge when the FIFO was empty.
- cmd_ready = (state==IDLE) && (count < DEPTH). This reserves the FIFO slot before accept, so a push never overflows.
- FIFO:
  - Pop when rsp_valid && rsp_ready.
  - Simultaneous push and pop keeps count unchanged, including when count==DEPTH-1 or count==DEPTH.
  - Pointers are log2(DEPTH) bits and wrap naturally.
  - rsp_* come directly from the head entry, not registered again.
- Opcode 15: the ALU is not consulted. Result is 0, flags are 0, rsp_illegal=1, and the last-result register is cleared to 0.
- Chain with no prior result uses 0.
- Reset mid-operation: an in-flight command is discarded, the FIFO is flushed and the last-result register is cleared.
- Outputs must not change while rsp_valid && !rsp_ready (stable head).

Optional Feature:
- Macro: ALU_CMD_STATS_EN.
- When defined, adds outputs stat_ops (16 bit, count of CAPT pushes) and stat_ovf (16 bit, count of pushes with overflow=1).
  - Both saturate at 16'hFFFF and clear on reset.
- When undefined, these ports and counters do not exist and behaviour is otherwise identical.

Decomposition:
- Package alu_cmd_pkg:
  - Opcode constants OP_ADD=4'd0, OP_SUB=4'd1 … OP_ILLEGAL=4'd15.
  - Flag bit indices FLG_ZERO=0, FLG_CARRY=1, FLG_OVF=2, FLG_NEG=3.
  - FSM state encoding (IDLE=2'd0, EXEC=2'd1, CAPT=2'd2).
- Sub-module alu_rsp_fifo: generic synchronous FIFO of width WIDTH+5 with DEPTH entries and push/pop/full/empty/count.
- The top instantiates `alu` and alu_rsp_fifo.

Test Plan:
- ADD 25+15 (sel=0, chain=0), rsp_ready=1 → rsp_valid 3 cycles after accept; out=40, flags=4'b0000, illegal=0.
- ADD 128+128 → out=0, flags zero=1, carry=1, overflow=1, negative=0.
- ADD 255+255, then chain ADD y=1 → first out=254 (carry=1, negative=1); second uses x=254, out=255, negative=1, carry=0.
- Hold rsp_ready=0, issue 6 commands back-to-back:
  - cmd_ready drops after 4 accepts.
  - Draining one entry re-raises cmd_ready the same cycle the count drops.
  - Results pop in issue order.
- sel=15 with x=7, y=9 → out=0, flags=0, illegal=1. A following chain ADD y=3 gives out=3.
- Assert rst_n=0 during EXEC with 2 entries queued → next cycle rsp_valid=0, and the discarded command never appears. With ALU_CMD_STATS_EN, stat_ops=0 after reset.
